// File: rtl/iir_out_decimator.sv
// iir_out_decimator: block-averaging decimator behind the IIR section.
// It sums 2^log2_decim input samples and divides by arithmetic shift, then saturates
// the average to out_width. The result goes into a first-word-fall-through FIFO
// with a valid/ready read port and a sticky overflow flag.
module iir_out_decimator #(
  parameter int bitwidth   = 32,
  parameter int out_width  = 16,
  parameter int log2_decim = 2,
  parameter int addr_width = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_en,
  input  logic signed [bitwidth-1:0]  x,
  output logic signed [out_width-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [addr_width:0]         fill,
  output logic                        overflow
);

  localparam int accw  = bitwidth + log2_decim;
  localparam int cntw  = (log2_decim > 0) ? log2_decim : 1;
  localparam int depth = 1 << addr_width;

  localparam logic [cntw-1:0]         last_phase = cntw'((1 << log2_decim) - 1);
  localparam logic [addr_width:0]     fill_full  = (addr_width + 1)'(depth);
  localparam logic signed [accw-1:0]  sat_max    = {{(accw - out_width + 1){1'b0}}, {(out_width - 1){1'b1}}};
  localparam logic signed [accw-1:0]  sat_min    = {{(accw - out_width + 1){1'b1}}, {(out_width - 1){1'b0}}};

  logic signed [accw-1:0]      acc;
  logic signed [accw-1:0]      sum;
  logic signed [accw-1:0]      avg;
  logic [cntw-1:0]             cnt;
  logic signed [out_width-1:0] result;
  logic [addr_width-1:0]       rd_ptr;
  logic [addr_width-1:0]       wr_ptr;
  logic signed [out_width-1:0] mem [depth];
  logic                        dump;
  logic                        pop;
  logic                        push;
  logic                        full;

  assign sum  = acc + accw'(x);
  assign avg  = sum >>> log2_decim;
  assign dump = in_en && (cnt == last_phase);
  assign full = (fill == fill_full);

  assign out_valid = (fill != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign push      = dump && (!full || pop);

  // Clamp the block average into the signed output range.
  always_comb begin
    result = avg[out_width-1:0];
    if (avg > sat_max) begin
      result = sat_max[out_width-1:0];
    end else if (avg < sat_min) begin
      result = sat_min[out_width-1:0];
    end
  end

  // Accumulate enabled samples; the last sample of a block clears the running sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_en) begin
      if (dump) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + cntw'(1);
      end
    end
  end

  // Circular FIFO: push and pop move their pointers, and a dump into a full FIFO sets overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= wr_ptr + addr_width'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + addr_width'(1);
      end
      if (push && !pop) begin
        fill <= fill + (addr_width + 1)'(1);
      end else if (pop && !push) begin
        fill <= fill - (addr_width + 1)'(1);
      end
      if (dump && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iir_out_decimator.sv
// tb_iir_out_decimator: directed and random stimulus for iir_out_decimator.
// The reference model keeps each block's samples and the FIFO contents in queues.
// It computes every average with floor division and clamping.
module tb_iir_out_decimator;

  localparam int bitwidth   = 32;
  localparam int out_width  = 16;
  localparam int log2_decim = 2;
  localparam int addr_width = 3;
  localparam int decim      = 1 << log2_decim;
  localparam int depth      = 1 << addr_width;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        in_en = 1'b0;
  logic signed [bitwidth-1:0]  x = '0;
  logic signed [out_width-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready = 1'b0;
  logic [addr_width:0]         fill;
  logic                        overflow;

  int     errors = 0;
  int     checks = 0;
  longint blockSamples[$];
  longint expFifo[$];
  bit     expOverflow = 1'b0;

  iir_out_decimator #(
    .bitwidth  (bitwidth),
    .out_width (out_width),
    .log2_decim(log2_decim),
    .addr_width(addr_width)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_en    (in_en),
    .x        (x),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fill     (fill),
    .overflow (overflow)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Floor-divide the block sum by the decimation factor, then clamp to the output range.
  function automatic longint averageBlock(input longint samples[$]);
    longint total;
    longint q;
    longint hi;
    longint lo;
    total = 0;
    foreach (samples[i]) total += samples[i];
    q = total / decim;
    if ((total % decim != 0) && (total < 0)) q = q - 1;
    hi = (longint'(1) <<< (out_width - 1)) - 1;
    lo = -(longint'(1) <<< (out_width - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  task automatic modelReset();
    blockSamples.delete();
    expFifo.delete();
    expOverflow = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".valid"}, longint'(out_valid), longint'(expFifo.size() != 0));
    check({tag, ".fill"}, longint'(fill), longint'(expFifo.size()));
    check({tag, ".overflow"}, longint'(overflow), longint'(expOverflow));
    if (expFifo.size() != 0) check({tag, ".data"}, longint'(out_data), expFifo[0]);
  endtask

  // Drive one cycle, advance the model, then check the outputs just after the edge.
  task automatic applyStimulus(input string tag, input bit en, input longint xv, input bit rdy);
    bit     popNow;
    longint r;
    in_en     = en;
    x         = xv[bitwidth-1:0];
    out_ready = rdy;
    popNow = (expFifo.size() != 0) && rdy;
    if (popNow) void'(expFifo.pop_front());
    if (en) begin
      blockSamples.push_back(longint'(x));
      if (blockSamples.size() == decim) begin
        r = averageBlock(blockSamples);
        blockSamples.delete();
        if (expFifo.size() < depth) expFifo.push_back(r);
        else expOverflow = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  function automatic longint randomSample();
    logic [31:0] raw;
    raw = $urandom;
    if ($urandom_range(0, 1) == 1) return longint'($signed(raw));
    return longint'($urandom_range(0, 100000)) - 50000;
  endfunction

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", longint'(out_valid), 0);
    check("reset.fill", longint'(fill), 0);
    check("reset.data", longint'(out_data), 0);
    check("reset.overflow", longint'(overflow), 0);
    rst = 1'b1;

    // Plain average: 100..400 gives 250, visible for exactly one cycle.
    applyStimulus("avg", 1, 100, 1);
    applyStimulus("avg", 1, 200, 1);
    applyStimulus("avg", 1, 300, 1);
    applyStimulus("avg", 1, 400, 1);
    check("avg.value", longint'(out_data), 250);
    applyStimulus("avg.after", 0, 0, 1);

    // Negative sum rounds toward minus infinity.
    applyStimulus("neg", 1, -1, 1);
    applyStimulus("neg", 1, -1, 1);
    applyStimulus("neg", 1, -1, 1);
    applyStimulus("neg", 1, -2, 1);
    check("neg.value", longint'(out_data), -2);

    // Saturation at both ends.
    for (int i = 0; i < 4; i++) applyStimulus("satpos", 1, 40000, 1);
    check("satpos.value", longint'(out_data), 32767);
    for (int i = 0; i < 4; i++) applyStimulus("satneg", 1, -40000, 1);
    check("satneg.value", longint'(out_data), -32768);

    // Disabled cycles are ignored.
    for (int i = 0; i < 4; i++) begin
      applyStimulus("toggle", 1, 4, 1);
      applyStimulus("toggle", 0, 1000, 1);
    end

    // Fill to 8, then dump while popping, then dump into a full FIFO, then drain.
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 4; i++) applyStimulus("fillup", 1, randomSample(), 0);
    check("fillup.full", longint'(fill), 8);
    for (int i = 0; i < 3; i++) applyStimulus("fullpop", 1, randomSample(), 0);
    applyStimulus("fullpop", 1, randomSample(), 1);
    check("fullpop.noovf", longint'(overflow), 0);
    for (int i = 0; i < 4; i++) applyStimulus("drop", 1, randomSample(), 0);
    check("drop.ovf", longint'(overflow), 1);
    for (int i = 0; i < 10; i++) applyStimulus("drain", 0, 0, 1);

    // Asynchronous reset mid-block with three buffered results.
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 4; i++) applyStimulus("prebuf", 1, randomSample(), 0);
    applyStimulus("partial", 1, 500, 0);
    applyStimulus("partial", 1, 700, 0);
    in_en = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    modelReset();
    check("areset.valid", longint'(out_valid), 0);
    check("areset.fill", longint'(fill), 0);
    check("areset.data", longint'(out_data), 0);
    check("areset.overflow", longint'(overflow), 0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) applyStimulus("postrst", 1, 8, 1);
    check("postrst.value", longint'(out_data), 8);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      applyStimulus("random", bit'($urandom_range(0, 1)), randomSample(), bit'($urandom_range(0, 2) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iir_out_decimator.md
# iir_out_decimator

Output-side stage placed directly downstream of the second-order IIR section. It consumes the filter's signed output stream, averages consecutive blocks of 2^log2_decim samples, arithmetically rescales the result, saturates it to the output width, and buffers it in a small FIFO. A valid/ready handshake delivers the buffered samples to the downstream consumer, such as a DAC or capture interface.

## Interface
- bitwidth, 32, width of the signed input samples (matches the filter's y)
- out_width, 16, width of the signed output samples; must be ≤ bitwidth
- log2_decim, 2, decimation factor N = 2^log2_decim (0 = no decimation)
- addr_width, 3, FIFO depth = 2^addr_width entries
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-low
- in_en  input  1  x is a valid filter sample this cycle
- x  input  bitwidth  signed sample from the IIR output
- out_data  output  out_width  signed decimated sample at FIFO head
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data this cycle
- fill  output  addr_width+1  current FIFO occupancy, 0..2^addr_width
- overflow  output  1  sticky flag: a result was dropped because the FIFO was full

## Operation
- Accumulator acc: signed, bitwidth+log2_decim bits. Phase counter cnt: log2_decim bits, range 0..N-1.
- On an in_en cycle with cnt < N-1: acc <= acc + x (sign-extended); cnt <= cnt+1.
- On an in_en cycle with cnt == N-1 (dump):
  - sum = acc + x.
  - avg = sum >>> log2_decim (arithmetic shift; rounds toward −inf).
  - avg saturates to [−2^(out_width−1), 2^(out_width−1)−1].
  - The result is pushed to the FIFO.
  - acc <= 0; cnt <= 0.
- With log2_decim = 0, every in_en sample is a dump.
- in_en low: acc and cnt hold. x is ignored.
- FIFO: circular buffer with rd_ptr, wr_ptr and occupancy counter fill. Reads are first-word-fall-through: out_data = mem[rd_ptr]; out_valid = (fill != 0).
- Pop: out_valid && out_ready at a rising edge. rd_ptr increments and wraps modulo depth.
- Push: a dump occurs, and either fill < depth or a pop happens in the same cycle. wr_ptr increments and wraps.
- Dump with fill == depth and no pop: the result is discarded, overflow <= 1, and pointers are unchanged. The accumulator still clears.
- Simultaneous push and pop: fill is unchanged. This applies when fill is full (push accepted) and when fill is nonzero.
- Push when fill == 0: there is no bypass path. The data appears at out_data the next cycle.
- overflow clears only on reset.
- Reset asserted, asynchronously and at any time:
  - acc = 0, cnt = 0.
  - rd_ptr = wr_ptr = 0, fill = 0.
  - out_valid = 0, overflow = 0.
  - out_data = 0, because FIFO memory entries are cleared on reset.
- Reset mid-block discards the partial sum and any buffered samples.

## Timing
- The dump happens at the rising edge that samples the N-th in_en sample. out_valid rises in the following cycle if the FIFO was empty: 1-cycle latency from the last contributing sample.
- out_data and out_valid are register-driven, with no combinational path from x or in_en.
- out_valid must not depend on out_ready. Once valid, out_data stays stable until popped.
- Sustained throughput: one output per N in_en cycles. With out_ready held high, the FIFO never exceeds 1 entry.
- Reset deassertion is synchronous to clk externally. The first accumulation uses the first in_en cycle after release.

## Test plan
- Defaults, out_ready=1, x = 100, 200, 300, 400 on consecutive in_en cycles -> out_data = 250 with out_valid for exactly 1 cycle, in the cycle after the 4th sample.
- Defaults, x = −1, −1, −1, −2 -> sum −5 >>> 2 = −2; out_data = −2 (0xFFFE).
- Saturation, defaults: four samples of 40000 -> out_data = 32767. Four samples of −40000 -> out_data = −32768.
- out_ready=0, feed 9 blocks of 4 samples -> fill reaches 8, 9th result dropped, overflow=1. Then raise out_ready -> 8 values drain in push order, fill counts down to 0, overflow stays 1.
- fill = 8 and out_ready=1 in the same cycle as a dump -> the dump is accepted, fill stays 8, overflow stays 0.
- Pull rst low asynchronously after 2 samples of a block and with 3 entries buffered:
  - Immediately: out_valid=0, fill=0, out_data=0.
  - After release, 4 samples of 8 -> out_data = 8, proving the partial sum was cleared.
- in_en toggling 1,0,1,0,... with x=4 on enabled cycles and x=1000 on disabled cycles -> output 4, showing disabled cycles are ignored.
